// File: rtl/step_clock_ctrl_pkg.sv
// Shared definitions for the step/run clock-enable controller.
package step_clock_ctrl_pkg;

  // Default widths of the controller datapaths.
  localparam int DEF_DIV_WIDTH   = 24;
  localparam int DEF_BURST_WIDTH = 8;
  localparam int DEF_CNT_WIDTH   = 32;

  // Controller state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/step_clock_ctrl_rise_detect.sv
// Registered copy of a level input plus a one-cycle rising-edge pulse.
// RESET_VAL sets the registered level on reset; a value of 1 stops an input
// that is held high through reset from producing a pulse when reset releases.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Track the previous-cycle value of the level input.
  always_ff @(posedge clk) begin
    if (reset) level_q <= RESET_VAL;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Core clock-enable generator: free-run with a prescaler, or step mode where
// each button press releases a burst of enables. halt freezes everything.
module step_clock_ctrl
  import step_clock_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_mode,
  input  logic                   step_btn,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic                   halt,
  output logic                   cpu_ce,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   ce_count,
  output logic                   mode_led
);

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [DIV_WIDTH-1:0]   prescale;
  logic [DIV_WIDTH-1:0]   prescale_next;
  logic [BURST_WIDTH-1:0] remaining;
  logic [BURST_WIDTH-1:0] remaining_next;
  logic                   issue;
  logic                   press;

  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_step_edge (
    .clk   (clk),
    .reset (reset),
    .level (step_btn),
    .rise  (press)
  );

  // Next-state, prescaler/burst bookkeeping and enable decision.
  always_comb begin
    state_next     = state;
    prescale_next  = prescale;
    remaining_next = remaining;
    issue          = 1'b0;
    if (!halt) begin
      case (state)
        ST_IDLE: begin
          if (run_mode) begin
            state_next = ST_RUN;
          end else if (press) begin
            state_next     = ST_BURST;
            remaining_next = (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;
          end
        end
        ST_BURST: begin
          issue          = 1'b1;
          remaining_next = remaining - BURST_WIDTH'(1);
          if (remaining <= BURST_WIDTH'(1))
            state_next = run_mode ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (!run_mode) begin
            state_next    = ST_IDLE;
            prescale_next = '0;
          end else if (prescale == div) begin
            prescale_next = '0;
            issue         = 1'b1;
          end else if (prescale > div) begin
            // div shrank below the running count: restart without an enable
            prescale_next = '0;
          end else begin
            prescale_next = prescale + DIV_WIDTH'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prescale  <= '0;
      remaining <= '0;
      cpu_ce    <= 1'b0;
      busy      <= 1'b0;
      mode_led  <= 1'b0;
    end else begin
      state     <= state_next;
      prescale  <= prescale_next;
      remaining <= remaining_next;
      cpu_ce    <= issue;
      busy      <= (state_next == ST_BURST);
      mode_led  <= (state_next == ST_RUN);
    end
  end

  // Count issued enables; wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (reset)       ce_count <= '0;
    else if (cpu_ce) ce_count <= ce_count + CNT_WIDTH'(1);
  end

endmodule
